// File: rtl/mac_ctrl_pkg.sv
// rtl/mac_ctrl_pkg.sv - shared widths, state encoding and pipeline depths for mac_ctrl
//
// Purpose: one place for the controller's default widths, the MAC datapath
// width, the FSM state encoding and the delay-line depths that line the
// control strobes up with the buffer read and MAC operand pipeline.
// Ports: none (package).

package mac_ctrl_pkg;

    // Default widths: input-buffer address, weight-buffer address,
    // length/count, and MAC operand data.
    localparam int MC_AWIDTH = 12;
    localparam int MC_WWIDTH = 16;
    localparam int MC_LWIDTH = 10;
    localparam int MC_DWIDTH = 16;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DRAIN = 2'd3
    } mc_state_e;

    // The address outputs are registered one cycle after the counters, then
    // the buffer read takes one cycle and the MAC operand registers another.
    // An issue therefore reaches the accumulator three cycles after the
    // counter cycle that produced it, and a clear travels the same path.
    localparam int ISSUE_DLY = 3;
    localparam int CLEAR_DLY = 3;
    // The output-register load follows the last accumulate by one cycle.
    localparam int LAST_DLY  = ISSUE_DLY + 1;

endpackage : mac_ctrl_pkg

// File: rtl/mac_ctrl_delay.sv
// rtl/mac_ctrl_delay.sv - fixed-depth shift register used for the control delay lines
//
// Purpose: delays a WIDTH-bit control word by exactly DEPTH clock cycles.
// Every stage is cleared by the synchronous reset, so nothing in flight
// survives a reset.
// Ports:
//   clk    in  1      clock, rising edge
//   reset  in  1      synchronous, active-high; clears every stage
//   din    in  WIDTH  word entering the line this cycle
//   dout   out WIDTH  word that entered DEPTH cycles ago (a flop output)

module ctrl_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = din;
        for (int s = 1; s < DEPTH; s++) begin
            stage_d[s] = stage_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < DEPTH; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                stage_q[s] <= stage_d[s];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule : ctrl_delay

// File: rtl/mac_ctrl.sv
// rtl/mac_ctrl.sv - sequencer for a fully-connected layer on a single MAC
//
// Purpose: for each of n_out neurons, clears the accumulator, streams n_in
// input/weight address pairs, then loads the MAC output register and flags
// the result with its neuron index. Weights are read row-major from one
// contiguous region starting at address 0. All outputs are flop outputs.
// Ports:
//   clk           in  1       clock, rising edge
//   reset         in  1       synchronous, active-high
//   start         in  1       job request, taken only in IDLE
//   n_in          in  LWIDTH  inputs per neuron, latched at an accepted start
//   n_out         in  LWIDTH  neuron count, latched at an accepted start
//   in_addr       out AWIDTH  input-buffer read address
//   w_addr        out WWIDTH  weight-buffer read address
//   mac_accum_we  out 1       accumulate strobe
//   mac_clear     out 1       accumulator clear
//   mac_out_en    out 1       MAC output-register load
//   out_valid     out 1       MAC result valid
//   out_addr      out LWIDTH  neuron index of the result under out_valid
//   busy          out 1       job in progress, through the done cycle
//   done          out 1       single-cycle completion pulse

module mac_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int AWIDTH = MC_AWIDTH,
    parameter int WWIDTH = MC_WWIDTH,
    parameter int LWIDTH = MC_LWIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LWIDTH-1:0] n_in,
    input  logic [LWIDTH-1:0] n_out,
    output logic [AWIDTH-1:0] in_addr,
    output logic [WWIDTH-1:0] w_addr,
    output logic              mac_accum_we,
    output logic              mac_clear,
    output logic              mac_out_en,
    output logic              out_valid,
    output logic [LWIDTH-1:0] out_addr,
    output logic              busy,
    output logic              done
);

    mc_state_e         state_q, state_d;
    logic [LWIDTH-1:0] i_q, i_d;
    logic [LWIDTH-1:0] k_q, k_d;
    logic [WWIDTH-1:0] w_q, w_d;
    logic [LWIDTH-1:0] n_in_q, n_in_d;
    logic [LWIDTH-1:0] n_out_q, n_out_d;
    logic [AWIDTH-1:0] in_addr_q, in_addr_d;
    logic [WWIDTH-1:0] w_addr_q, w_addr_d;
    logic              out_valid_q, out_valid_d;
    logic [LWIDTH-1:0] out_addr_q, out_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              issue;
    logic              clear_now;
    logic              last_issue;
    logic              last_neuron;
    logic              accum_dly;
    logic              clear_dly;
    logic              last_dly;
    logic [LWIDTH-1:0] idx_dly;

    always_comb begin
        issue       = (state_q == ST_ISSUE);
        clear_now   = (state_q == ST_CLEAR);
        last_issue  = issue && (i_q == n_in_q - LWIDTH'(1));
        last_neuron = (k_q == n_out_q - LWIDTH'(1));
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        k_d     = k_q;
        w_d     = w_q;
        n_in_d  = n_in_q;
        n_out_d = n_out_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((n_in != '0) && (n_out != '0)) begin
                        n_in_d  = n_in;
                        n_out_d = n_out;
                        i_d     = '0;
                        k_d     = '0;
                        w_d     = '0;
                        state_d = ST_CLEAR;
                    end else begin
                        // Empty job: acknowledge without touching the MAC.
                        done_d = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                i_d     = '0;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                i_d = i_q + LWIDTH'(1);
                // Weight address runs on across neurons and wraps freely.
                w_d = w_q + WWIDTH'(1);
                if (last_issue) begin
                    if (!last_neuron) begin
                        k_d     = k_q + LWIDTH'(1);
                        state_d = ST_CLEAR;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Earlier neurons may still be in the delay line when DRAIN
                // is entered, so finish only on the final neuron's load.
                if (last_dly && (idx_dly == n_out_q - LWIDTH'(1))) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Busy covers the completion cycle of a real job but not the
        // acknowledge of an empty one.
        busy_d = (state_d != ST_IDLE) || ((state_q == ST_DRAIN) && done_d);

        in_addr_d   = AWIDTH'(i_q);
        w_addr_d    = w_q;
        out_valid_d = last_dly;
        out_addr_d  = last_dly ? idx_dly : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            i_q         <= '0;
            k_q         <= '0;
            w_q         <= '0;
            n_in_q      <= '0;
            n_out_q     <= '0;
            in_addr_q   <= '0;
            w_addr_q    <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            k_q         <= k_d;
            w_q         <= w_d;
            n_in_q      <= n_in_d;
            n_out_q     <= n_out_d;
            in_addr_q   <= in_addr_d;
            w_addr_q    <= w_addr_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    ctrl_delay #(.WIDTH(1), .DEPTH(ISSUE_DLY)) u_issue_dly (
        .clk   (clk),
        .reset (reset),
        .din   (issue),
        .dout  (accum_dly)
    );

    ctrl_delay #(.WIDTH(1), .DEPTH(CLEAR_DLY)) u_clear_dly (
        .clk   (clk),
        .reset (reset),
        .din   (clear_now),
        .dout  (clear_dly)
    );

    ctrl_delay #(.WIDTH(1), .DEPTH(LAST_DLY)) u_last_dly (
        .clk   (clk),
        .reset (reset),
        .din   (last_issue),
        .dout  (last_dly)
    );

    // Neuron index travels alongside the last-issue marker.
    ctrl_delay #(.WIDTH(LWIDTH), .DEPTH(LAST_DLY)) u_index_dly (
        .clk   (clk),
        .reset (reset),
        .din   (k_q),
        .dout  (idx_dly)
    );

    assign in_addr      = in_addr_q;
    assign w_addr       = w_addr_q;
    assign mac_accum_we = accum_dly;
    assign mac_clear    = clear_dly;
    assign mac_out_en   = last_dly;
    assign out_valid    = out_valid_q;
    assign out_addr     = out_addr_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule : mac_ctrl

// File: doc/mac_ctrl.md
MAC_CTRL -- requirements
Module: mac_ctrl

Interface
REQ-001 Parameters: AWIDTH, default 12, input-buffer address width; WWIDTH, default 16, weight-buffer address width; LWIDTH, default 10, length/count width.
REQ-002 clk  in  1  clock; all logic on rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  single-cycle job request; accepted only in IDLE.
REQ-005 n_in  in  LWIDTH  input-vector length per neuron; latched at accepted start.
REQ-006 n_out  in  LWIDTH  output-neuron count; latched at accepted start.
REQ-007 in_addr  out  AWIDTH  input-buffer read address.
REQ-008 w_addr  out  WWIDTH  weight-buffer read address.
REQ-009 mac_accum_we  out  1  accumulate strobe to MAC.
REQ-010 mac_clear  out  1  accumulator clear to MAC.
REQ-011 mac_out_en  out  1  MAC output-register load.
REQ-012 out_valid  out  1  MAC result valid this cycle.
REQ-013 out_addr  out  LWIDTH  neuron index of the result under out_valid.
REQ-014 busy  out  1  job in progress; done  out  1  single-cycle completion pulse.

Function
REQ-015 States: IDLE, CLEAR, ISSUE, DRAIN. IDLE->CLEAR on start with n_in>0 and n_out>0.
REQ-016 The block SHALL treat start with n_in=0 or n_out=0 as an empty job: it SHALL pulse done the next cycle with no strobes and remain in IDLE.
REQ-017 CLEAR lasts 1 cycle and resets i to 0. CLEAR->ISSUE.
REQ-018 ISSUE: each cycle drives in_addr=i, asserts issue and increments i and w_addr.
REQ-019 At i=n_in-1, ISSUE SHALL go to CLEAR for neuron k+1 if k<n_out-1, else to DRAIN.
REQ-020 w_addr SHALL be 0 at accepted start, increment once per issue, and never reset between neurons (row-major, contiguous).
REQ-021 Memory read latency is 1 cycle. MAC operand registers add 1 cycle.
REQ-022 mac_accum_we = issue delayed 2 cycles. mac_clear = CLEAR-state delayed 2 cycles.
REQ-023 mac_out_en = (last issue of a neuron) delayed 3 cycles.
REQ-024 out_valid = mac_out_en delayed 1 cycle. out_addr = k carried through the same delay.
REQ-025 mac_clear and mac_out_en of consecutive neurons SHALL coincide in one cycle; this is legal.
REQ-026 Throughput SHALL be n_in+1 cycles per neuron with no further bubbles.
REQ-027 mac_accum_we and mac_clear SHALL never be high in the same cycle.
REQ-028 DRAIN waits until the delay lines are empty, then returns to IDLE.
REQ-029 done SHALL pulse in the cycle of the final out_valid.
REQ-030 busy SHALL be high from the cycle after an accepted start through the done cycle inclusive.
REQ-031 start while busy SHALL be ignored, with no effect on the latched n_in/n_out.
REQ-032 Counters i and k SHALL be LWIDTH wide. w_addr SHALL wrap modulo 2^WWIDTH, with no overflow flag.

Reset
REQ-033 On reset the block SHALL force IDLE and clear all counters and every delay-line stage.
REQ-034 On reset all outputs SHALL be 0 from the next cycle.
REQ-035 Reset mid-job SHALL abandon the job with no later strobe, out_valid or done.
REQ-036 reset SHALL take priority over start in the same cycle.

Structure
REQ-037 LWIDTH/AWIDTH/WWIDTH defaults, DWIDTH and the state encoding SHALL live in the shared gobou header/package.
REQ-038 One sub-module, ctrl_delay, SHALL be used: parameterized width/depth shift register with synchronous reset, instantiated for the issue, clear, last and index paths.
REQ-039 The implementation SHALL be a single FSM plus counters, with no combinational path from inputs to outputs.

Verification
REQ-040 Case n_in=4, n_out=1, start at cycle 0:
- mac_clear at cycle 4.
- mac_accum_we at cycles 5-8.
- mac_out_en at cycle 9.
- out_valid, out_addr=0 and done at cycle 10.
REQ-041 Case n_in=3, n_out=3, weights=index, inputs=1:
- results are 3, 12, 21 at out_addr 0, 1, 2.
- out_valid spacing is 4 cycles.
- mac_clear coincides with mac_out_en for neurons 1 and 2.
REQ-042 Case n_in=1, n_out=2:
- accum_we is high 1 cycle per neuron.
- w_addr sequence is 0, 1.
- 2 out_valid pulses, 2 cycles apart.
REQ-043 Case n_in=0: done pulses 1 cycle after start, with busy and all strobes held at 0.
REQ-044 Case reset asserted mid-ISSUE (n_in=8, n_out=2, cycle 6): all outputs are 0 next cycle and no strobe appears afterwards.
REQ-045 Case second start during busy: ignored; the first job completes with the original n_in/n_out.
